// File: rtl/uart_cmd_bridge.sv
// Serial-debug command responder: pops 'W addr data' / 'R addr' frames from the UART RX FIFO,
// runs one register-bus transaction per frame and pushes a one-byte reply into the UART TX FIFO.
module uart_cmd_bridge #(
  parameter int TimeoutBits    = 16,
  parameter int AckTimeoutBits = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_fifo_empty,
  output logic       o_fifo_read,
  input  logic [7:0] i_fifo_rdata,
  input  logic       i_fifo_full,
  output logic       o_fifo_write,
  output logic [7:0] o_fifo_wdata,
  output logic       o_reg_req,
  output logic       o_reg_we,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  input  logic       i_reg_ack,
  input  logic [7:0] i_reg_rdata,
  output logic       o_frame_err
);

  // state    | meaning
  // IDLE     | waiting for an opcode byte
  // GET_ADDR | opcode accepted, waiting for the address byte
  // GET_DATA | write frame, waiting for the data byte
  // BUS      | register request outstanding
  // RESP     | reply byte loaded, waiting for TX FIFO space

  localparam logic [7:0] OpWrite = 8'h57;
  localparam logic [7:0] OpRead  = 8'h52;
  localparam logic [7:0] RespAck = 8'h06;
  localparam logic [7:0] RespNak = 8'h15;

  // Both timeouts fire on the cycle whose increment would reach all-ones.
  localparam logic [TimeoutBits-1:0]    IbtLast = ~TimeoutBits'(1);
  localparam logic [AckTimeoutBits-1:0] AckLast = ~AckTimeoutBits'(1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [TimeoutBits-1:0]    ibt_cnt;
  logic [AckTimeoutBits-1:0] ack_cnt;
  logic                      mid_frame;
  logic                      opcode_ok;
  logic                      ibt_expire;
  logic                      ack_expire;

  assign mid_frame  = (state == GET_ADDR) || (state == GET_DATA);
  assign opcode_ok  = (i_fifo_rdata == OpWrite) || (i_fifo_rdata == OpRead);
  assign ibt_expire = mid_frame && !o_fifo_read && (ibt_cnt == IbtLast);
  assign ack_expire = (state == BUS) && !i_reg_ack && (ack_cnt == AckLast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (o_fifo_read) begin
          state_nxt = opcode_ok ? GET_ADDR : RESP;
        end
      end
      GET_ADDR: begin
        if (o_fifo_read) begin
          state_nxt = o_reg_we ? GET_DATA : BUS;
        end else if (ibt_expire) begin
          state_nxt = IDLE;
        end
      end
      GET_DATA: begin
        if (o_fifo_read) begin
          state_nxt = BUS;
        end else if (ibt_expire) begin
          state_nxt = IDLE;
        end
      end
      BUS: begin
        if (i_reg_ack || ack_expire) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (!i_fifo_full) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_fifo_read  = 1'b0;
    o_fifo_write = 1'b0;
    if ((state == IDLE) || mid_frame) begin
      o_fifo_read = !i_fifo_empty;
    end
    if (state == RESP) begin
      o_fifo_write = !i_fifo_full;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_reg_req    <= 1'b0;
      o_reg_we     <= 1'b0;
      o_reg_addr   <= 8'h00;
      o_reg_wdata  <= 8'h00;
      o_fifo_wdata <= 8'h00;
      o_frame_err  <= 1'b0;
      ibt_cnt      <= '0;
      ack_cnt      <= '0;
    end else begin
      o_reg_req   <= (state_nxt == BUS);
      o_frame_err <= ibt_expire;

      if (mid_frame && !o_fifo_read && !ibt_expire) begin
        ibt_cnt <= ibt_cnt + TimeoutBits'(1);
      end else begin
        ibt_cnt <= '0;
      end

      if ((state == BUS) && (state_nxt == BUS)) begin
        ack_cnt <= ack_cnt + AckTimeoutBits'(1);
      end else begin
        ack_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (o_fifo_read) begin
            o_reg_we <= (i_fifo_rdata == OpWrite);
            if (!opcode_ok) begin
              o_fifo_wdata <= RespNak;
            end
          end
        end
        GET_ADDR: begin
          if (o_fifo_read) begin
            o_reg_addr <= i_fifo_rdata;
          end
        end
        GET_DATA: begin
          if (o_fifo_read) begin
            o_reg_wdata <= i_fifo_rdata;
          end
        end
        BUS: begin
          if (i_reg_ack) begin
            o_fifo_wdata <= o_reg_we ? RespAck : i_reg_rdata;
          end else if (ack_expire) begin
            o_fifo_wdata <= RespNak;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge: frame-level reference model with a per-cycle monitor,
// plus hand-computed timing and data expectations for each scenario.
module tb_uart_cmd_bridge;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_fifo_empty;
  logic       o_fifo_read;
  logic [7:0] i_fifo_rdata;
  logic       i_fifo_full = 1'b0;
  logic       o_fifo_write;
  logic [7:0] o_fifo_wdata;
  logic       o_reg_req;
  logic       o_reg_we;
  logic [7:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic       i_reg_ack = 1'b0;
  logic [7:0] i_reg_rdata = 8'hEE;
  logic       o_frame_err;

  uart_cmd_bridge #(.TimeoutBits(4), .AckTimeoutBits(3)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_read  (o_fifo_read),
    .i_fifo_rdata (i_fifo_rdata),
    .i_fifo_full  (i_fifo_full),
    .o_fifo_write (o_fifo_write),
    .o_fifo_wdata (o_fifo_wdata),
    .o_reg_req    (o_reg_req),
    .o_reg_we     (o_reg_we),
    .o_reg_addr   (o_reg_addr),
    .o_reg_wdata  (o_reg_wdata),
    .i_reg_ack    (i_reg_ack),
    .i_reg_rdata  (i_reg_rdata),
    .o_frame_err  (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RX FIFO: first-word fall-through, popped on the edge where o_fifo_read is high
  logic [7:0] rx_mem [0:255];
  logic [7:0] rx_head = 8'h00;
  logic [7:0] rx_tail = 8'h00;
  assign i_fifo_empty = (rx_head == rx_tail);
  assign i_fifo_rdata = rx_mem[rx_head];
  always @(posedge i_clk) if (o_fifo_read && i_rst_n) rx_head <= rx_head + 8'd1;

  task automatic send(input logic [7:0] b);
    rx_mem[rx_tail] = b;
    rx_tail = rx_tail + 8'd1;
  endtask

  // Register-bus responder: acks on the (ack_delay+1)-th request cycle unless ack_never
  int         ack_delay = 0;
  bit         ack_never = 1'b0;
  logic [7:0] rd_value = 8'h00;
  int         req_age = 0;
  always @(negedge i_clk) begin
    i_reg_ack   = 1'b0;
    i_reg_rdata = 8'hEE;
    if (o_reg_req) begin
      if (!ack_never && req_age == ack_delay) begin
        i_reg_ack   = 1'b1;
        i_reg_rdata = rd_value;
      end
      req_age++;
    end else begin
      req_age = 0;
    end
  end

  // Frame-level reference model
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;
  req_t       exp_req_q[$];
  logic [7:0] exp_tx_q[$];
  int         err_exp = 0;

  task automatic expect_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data,
                              input int nbytes, input bit acked, input logic [7:0] rd);
    req_t r;
    if (op != 8'h57 && op != 8'h52) begin
      exp_tx_q.push_back(8'h15);
    end else if (nbytes < ((op == 8'h57) ? 3 : 2)) begin
      err_exp++;
    end else begin
      r.we    = (op == 8'h57);
      r.addr  = addr;
      r.wdata = r.we ? data : 8'h00;
      exp_req_q.push_back(r);
      if (!acked)     exp_tx_q.push_back(8'h15);
      else if (r.we)  exp_tx_q.push_back(8'h06);
      else            exp_tx_q.push_back(rd);
    end
  endtask

  // Per-cycle monitor; events seen at sample s take effect on the following rising edge
  int         sample = 0;
  int         pops_seen = 0, pushes = 0, reqs_seen = 0, err_seen = 0;
  int         last_pop_s = 0, req_rise_s = 0, write_s = 0, err_s = 0;
  int         req_run = 0, last_req_run = 0;
  logic       prev_req = 1'b0, prev_err = 1'b0, prev_write = 1'b0;
  logic [7:0] last_tx = 8'h00;
  req_t       held, last_req;

  always @(negedge i_clk) begin
    #2;
    sample++;
    if (!i_rst_n) begin
      prev_req = 1'b0;
      prev_err = 1'b0;
      prev_write = 1'b0;
      req_run = 0;
    end else begin
      if (o_fifo_read) begin
        check("pop_when_empty", i_fifo_empty, 1'b0);
        pops_seen++;
        last_pop_s = sample;
      end
      if (o_reg_req && !prev_req) begin
        req_rise_s = sample;
        reqs_seen++;
        req_run = 0;
        held = '{o_reg_we, o_reg_addr, o_reg_wdata};
        last_req = held;
        check("req_expected", exp_req_q.size() != 0, 1'b1);
        if (exp_req_q.size() != 0) begin
          check("req_we", o_reg_we, exp_req_q[0].we);
          check("req_addr", o_reg_addr, exp_req_q[0].addr);
          if (exp_req_q[0].we) check("req_wdata", o_reg_wdata, exp_req_q[0].wdata);
          void'(exp_req_q.pop_front());
        end
      end else if (o_reg_req) begin
        check("req_stable", {o_reg_we, o_reg_addr, o_reg_wdata}, {held.we, held.addr, held.wdata});
      end
      if (o_reg_req) req_run++;
      if (!o_reg_req && prev_req) last_req_run = req_run;
      if (o_fifo_write) begin
        if (!prev_write) write_s = sample;
        pushes++;
        last_tx = o_fifo_wdata;
        check("push_when_full", i_fifo_full, 1'b0);
        check("tx_expected", exp_tx_q.size() != 0, 1'b1);
        if (exp_tx_q.size() != 0) check("tx_byte", o_fifo_wdata, exp_tx_q.pop_front());
      end
      if (o_frame_err) begin
        err_seen++;
        err_s = sample;
        check("frame_err_width", prev_err, 1'b0);
      end
      prev_req = o_reg_req;
      prev_err = o_frame_err;
      prev_write = o_fifo_write;
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while ((rx_head != rx_tail || exp_tx_q.size() != 0 || exp_req_q.size() != 0 ||
            err_seen != err_exp) && n < 300) begin
      @(negedge i_clk); #3;
      n++;
    end
    check({name, "_timeout"}, n < 300, 1'b1);
    repeat (3) begin @(negedge i_clk); #3; end
    check({name, "_req_q"}, exp_req_q.size(), 0);
    check({name, "_tx_q"}, exp_tx_q.size(), 0);
    check({name, "_err_cnt"}, err_seen, err_exp);
  endtask

  int p0, q0, r0, n;

  initial begin
    for (int i = 0; i < 256; i++) rx_mem[i] = 8'hEE;
    repeat (3) @(negedge i_clk);
    #3;
    check("rst_reg_req", o_reg_req, 1'b0);
    check("rst_reg_we", o_reg_we, 1'b0);
    check("rst_reg_addr", o_reg_addr, 8'h00);
    check("rst_reg_wdata", o_reg_wdata, 8'h00);
    check("rst_frame_err", o_frame_err, 1'b0);
    check("rst_fifo_wdata", o_fifo_wdata, 8'h00);
    check("rst_fifo_write", o_fifo_write, 1'b0);
    check("rst_fifo_read", o_fifo_read, 1'b0);
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // write frame, ack on the 4th request cycle
    p0 = pops_seen;
    ack_delay = 3;
    expect_frame(8'h57, 8'h10, 8'hA5, 3, 1'b1, 8'h00);
    @(negedge i_clk);
    send(8'h57); send(8'h10); send(8'hA5);
    wait_idle("wr");
    check("wr_pops", pops_seen - p0, 3);
    check("wr_tx", last_tx, 8'h06);
    check("wr_req", {last_req.we, last_req.addr, last_req.wdata}, {1'b1, 8'h10, 8'hA5});
    check("wr_req_cycles", last_req_run, 4);

    // read frame, immediate ack: minimum latency
    ack_delay = 0;
    rd_value = 8'h3C;
    expect_frame(8'h52, 8'h22, 8'h00, 2, 1'b1, 8'h3C);
    @(negedge i_clk);
    send(8'h52); send(8'h22);
    wait_idle("rd");
    check("rd_tx", last_tx, 8'h3C);
    check("rd_req", {last_req.we, last_req.addr}, {1'b0, 8'h22});
    check("rd_req_latency", req_rise_s - last_pop_s, 1);
    check("rd_write_latency", write_s - last_pop_s, 2);

    // bad opcode then a normal read
    p0 = pops_seen; r0 = reqs_seen;
    rd_value = 8'h77;
    expect_frame(8'h41, 8'h00, 8'h00, 1, 1'b1, 8'h00);
    expect_frame(8'h52, 8'h01, 8'h00, 2, 1'b1, 8'h77);
    @(negedge i_clk);
    send(8'h41); send(8'h52); send(8'h01);
    wait_idle("badop");
    check("badop_pops", pops_seen - p0, 3);
    check("badop_reqs", reqs_seen - r0, 1);
    check("badop_tx", last_tx, 8'h77);

    // truncated write frame: inter-byte timeout
    r0 = reqs_seen; q0 = pushes;
    expect_frame(8'h57, 8'h10, 8'h00, 2, 1'b1, 8'h00);
    @(negedge i_clk);
    send(8'h57); send(8'h10);
    wait_idle("ibt");
    check("ibt_err_delay", err_s - last_pop_s, 16);
    check("ibt_reqs", reqs_seen - r0, 0);
    check("ibt_pushes", pushes - q0, 0);
    rd_value = 8'hC3;
    expect_frame(8'h52, 8'h05, 8'h00, 2, 1'b1, 8'hC3);
    @(negedge i_clk);
    send(8'h52); send(8'h05);
    wait_idle("ibt_after");
    check("ibt_after_tx", last_tx, 8'hC3);

    // bus never acks
    ack_never = 1'b1;
    expect_frame(8'h52, 8'h30, 8'h00, 2, 1'b0, 8'h00);
    @(negedge i_clk);
    send(8'h52); send(8'h30);
    wait_idle("ackto");
    check("ackto_req_cycles", last_req_run, 7);
    check("ackto_tx", last_tx, 8'h15);
    ack_never = 1'b0;

    // TX full stall with a second frame already waiting in RX
    p0 = pops_seen; q0 = pushes; r0 = reqs_seen;
    rd_value = 8'h99;
    expect_frame(8'h52, 8'h07, 8'h00, 2, 1'b1, 8'h99);
    expect_frame(8'h52, 8'h08, 8'h00, 2, 1'b1, 8'h5A);
    @(negedge i_clk);
    i_fifo_full = 1'b1;
    send(8'h52); send(8'h07); send(8'h52); send(8'h08);
    n = 0;
    while (!(reqs_seen > r0 && !o_reg_req) && n < 100) begin @(negedge i_clk); #3; n++; end
    check("stall_reach_resp", n < 100, 1'b1);
    check("stall_pops_before", pops_seen - p0, 2);
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk); #3;
      check("stall_no_write", o_fifo_write, 1'b0);
      check("stall_no_read", o_fifo_read, 1'b0);
    end
    rd_value = 8'h5A;
    @(negedge i_clk);
    i_fifo_full = 1'b0;
    wait_idle("stall");
    check("stall_pushes", pushes - q0, 2);
    check("stall_pops", pops_seen - p0, 4);
    check("stall_tx", last_tx, 8'h5A);

    // reset while a request is outstanding
    ack_never = 1'b1;
    exp_req_q.push_back('{1'b0, 8'h40, 8'h00});
    @(negedge i_clk);
    send(8'h52); send(8'h40);
    n = 0;
    while (!o_reg_req && n < 50) begin @(negedge i_clk); #3; n++; end
    check("rst_bus_reach", o_reg_req, 1'b1);
    @(negedge i_clk); #3;
    q0 = pushes;
    i_rst_n = 1'b0;
    #1;
    check("rst_bus_req_drop", o_reg_req, 1'b0);
    check("rst_bus_no_write", o_fifo_write, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    ack_never = 1'b0;
    repeat (20) begin @(negedge i_clk); #3; end
    check("rst_bus_pushes", pushes - q0, 0);
    check("rst_bus_req_low", o_reg_req, 1'b0);
    rd_value = 8'h4D;
    expect_frame(8'h52, 8'h41, 8'h00, 2, 1'b1, 8'h4D);
    @(negedge i_clk);
    send(8'h52); send(8'h41);
    wait_idle("rst_after");
    check("rst_after_tx", last_tx, 8'h4D);
    check("rst_after_addr", last_req.addr, 8'h41);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected finish before 100000", $time);
    $fatal(1);
  end

endmodule
